// File: rtl/mem_access_initiator_if.sv
// Bundle of the pipeline request/response and data-memory signals around the MEM-stage initiator.
// The master modport is the initiator's view; slave is the pipeline plus memory side.
interface mem_access_initiator_if #(
    parameter int unsigned MEM_AW = 8
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [1:0]        ReqSize;
    logic              ReqSigned;
    logic [31:0]       AlUResult;
    logic [31:0]       ReadData2;
    logic              RespValid;
    logic [31:0]       LoadData;
    logic              Misaligned;
    logic              Timeout;
    logic              Stall;
    logic              MemRead;
    logic              MemWrite;
    logic [MEM_AW-1:0] MemAddress;
    logic [3:0]        MemByteEn;
    logic [31:0]       MemWriteData;
    logic [31:0]       MemReadData;
    logic              MemAck;

    modport master (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, AlUResult, ReadData2,
        input  MemReadData, MemAck,
        output ReqReady, RespValid, LoadData, Misaligned, Timeout, Stall,
        output MemRead, MemWrite, MemAddress, MemByteEn, MemWriteData
    );

    modport slave (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, AlUResult, ReadData2,
        output MemReadData, MemAck,
        input  ReqReady, RespValid, LoadData, Misaligned, Timeout, Stall,
        input  MemRead, MemWrite, MemAddress, MemByteEn, MemWriteData
    );
endinterface

// File: rtl/mem_access_initiator.sv
// MEM-stage load/store initiator: turns a byte-addressed request into a word access with
// byte enables, waits for MemAck (bounded by TIMEOUT) and returns extended load data.
module mem_access_initiator #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned MEM_AW  = 8
) (
    input logic                    Clk,
    input logic                    Rst_n,
    mem_access_initiator_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR} state_t;

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [1:0]        r_addr_lo;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_write;
    logic              r_resp_valid;
    logic [31:0]       r_load_data;
    logic              r_misaligned;
    logic              r_timeout;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [3:0]        r_byte_en;
    logic [31:0]       r_wdata;

    logic              w_misaligned;
    logic [3:0]        w_byte_en;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load_ext;

    // Request decode: alignment check and store lane formatting from the live request bus.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_misaligned = 1'b0;
        w_byte_en    = 4'b0000;
        w_wdata      = bus.ReadData2;
        case (bus.ReqSize)
            2'd0: begin
                w_byte_en = 4'b0001 << bus.AlUResult[1:0];
                w_wdata   = {4{bus.ReadData2[7:0]}};
            end
            2'd1: begin
                w_misaligned = bus.AlUResult[0];
                w_byte_en    = bus.AlUResult[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{bus.ReadData2[15:0]}};
            end
            2'd2: begin
                w_misaligned = (bus.AlUResult[1:0] != 2'b00);
                w_byte_en    = 4'b1111;
            end
            default: w_misaligned = 1'b1;
        endcase
    end

    // Load extraction: aligned halfwords sit at lane 0 or 2, so one shift serves both sizes.
    always_comb begin
        w_shifted  = bus.MemReadData >> {r_addr_lo, 3'b000};
        w_load_ext = bus.MemReadData;
        case (r_size)
            2'd0:    w_load_ext = {{24{r_signed & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_load_ext = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_ext = bus.MemReadData;
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every update
    // in this block sees the values from before the clock edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr_lo    <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_write      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_load_data  <= '0;
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_byte_en    <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ReqValid) begin
                        r_addr_lo <= bus.AlUResult[1:0];
                        r_size    <= bus.ReqSize;
                        r_signed  <= bus.ReqSigned;
                        r_write   <= bus.ReqWrite;
                        r_cnt     <= '0;
                        if (w_misaligned) begin
                            r_state      <= S_ERR;
                            r_resp_valid <= 1'b1;
                            r_misaligned <= 1'b1;
                            r_load_data  <= '0;
                        end else begin
                            r_state     <= S_ACCESS;
                            r_mem_read  <= ~bus.ReqWrite;
                            r_mem_write <= bus.ReqWrite;
                            r_mem_addr  <= bus.AlUResult[MEM_AW+1:2];
                            r_byte_en   <= w_byte_en;
                            r_wdata     <= w_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (bus.MemAck) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_load_data  <= r_write ? 32'd0 : w_load_ext;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_timeout    <= 1'b1;
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_load_data  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP, S_ERR: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_misaligned <= 1'b0;
                    r_timeout    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Ready and stall are decoded so the pipeline freezes in the same cycle a request appears.
    assign bus.ReqReady     = (r_state == S_IDLE);
    assign bus.Stall        = (r_state == S_ACCESS) || ((r_state == S_IDLE) && bus.ReqValid);
    assign bus.RespValid    = r_resp_valid;
    assign bus.LoadData     = r_load_data;
    assign bus.Misaligned   = r_misaligned;
    assign bus.Timeout      = r_timeout;
    assign bus.MemRead      = r_mem_read;
    assign bus.MemWrite     = r_mem_write;
    assign bus.MemAddress   = r_mem_addr;
    assign bus.MemByteEn    = r_byte_en;
    assign bus.MemWriteData = r_wdata;
endmodule

// File: tb/tb_mem_access_initiator.sv
// Self-checking bench for mem_access_initiator: directed cases plus random transactions,
// checked against a byte-level memory and request model kept in the bench.
module tb_mem_access_initiator;
    localparam int unsigned T  = 15;
    localparam int unsigned AW = 8;

    logic Clk = 1'b0;
    logic Rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] mem [256];

    always #5 Clk = ~Clk;

    mem_access_initiator_if #(.MEM_AW(AW)) bus ();

    mem_access_initiator #(.TIMEOUT(T), .MEM_AW(AW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---- reference model ----
    function automatic bit m_misaligned(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
        int lane = int'(addr % 4);
        if (size == 2'd0) return 4'(1 << lane);
        if (size == 2'd1) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] data);
        if (size == 2'd0) return (data & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (data & 32'hFFFF) * 32'h0001_0001;
        return data;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input bit sgn,
                                           input logic [31:0] addr, input logic [31:0] word);
        int nbytes = 1 << size;
        logic [31:0] mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        logic [31:0] v = (word >> (8 * (addr % 4))) & mask;
        if (sgn && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [AW-1:0] m_widx(input logic [31:0] addr);
        return AW'((addr / 4) % (1 << AW));
    endfunction

    // ack_delay: ACCESS cycles without ack before the ack cycle; negative means never ack.
    task automatic do_txn(input string tag, input bit wr, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] data, input int ack_delay);
        bit            mis    = m_misaligned(size, addr);
        logic [AW-1:0] widx   = m_widx(addr);
        int            cycles = 0;
        int            exp_cycles;
        logic [3:0]    be;
        logic [31:0]   wd;
        be = m_be(size, addr);
        wd = m_wdata(size, data);
        @(negedge Clk);
        bus.ReqValid    = 1'b1;
        bus.ReqWrite    = wr;
        bus.ReqSize     = size;
        bus.ReqSigned   = sgn;
        bus.AlUResult   = addr;
        bus.ReadData2   = data;
        bus.MemAck      = 1'b0;
        bus.MemReadData = mem[widx];
        #1;
        check({tag, " ready"}, bus.ReqReady, 1);
        check({tag, " stall_req"}, bus.Stall, 1);
        @(posedge Clk);
        #1;
        if (mis) begin
            bus.ReqValid = 1'b0;
            bus.MemAck   = 1'($urandom_range(0, 1));
            check({tag, " err_resp"}, bus.RespValid, 1);
            check({tag, " err_flag"}, bus.Misaligned, 1);
            check({tag, " err_to"}, bus.Timeout, 0);
            check({tag, " err_ld"}, bus.LoadData, 0);
            check({tag, " err_strobes"}, {bus.MemRead, bus.MemWrite}, 0);
            check({tag, " err_stall"}, bus.Stall, 0);
            check({tag, " err_ready"}, bus.ReqReady, 0);
            @(posedge Clk);
            #1;
            bus.MemAck = 1'b0;
            check({tag, " err_done"}, bus.RespValid, 0);
            check({tag, " err_idle"}, bus.ReqReady, 1);
            check({tag, " err_nostrobe"}, {bus.MemRead, bus.MemWrite}, 0);
            return;
        end
        check({tag, " addr"}, bus.MemAddress, widx);
        check({tag, " be"}, bus.MemByteEn, be);
        check({tag, " strobes"}, {bus.MemRead, bus.MemWrite}, {~wr, wr});
        if (wr) check({tag, " wdata"}, bus.MemWriteData, wd);
        check({tag, " no_early_resp"}, bus.RespValid, 0);
        while (1) begin
            // ACCESS cycle: unrelated requests on the bus must be ignored
            bus.MemAck    = (ack_delay >= 0 && cycles == ack_delay);
            bus.ReqValid  = 1'($urandom_range(0, 1));
            bus.ReqWrite  = 1'($urandom_range(0, 1));
            bus.ReqSize   = 2'($urandom_range(0, 3));
            bus.AlUResult = $urandom;
            bus.ReadData2 = $urandom;
            check({tag, " stall_busy"}, bus.Stall, 1);
            @(posedge Clk);
            #1;
            cycles++;
            if (bus.RespValid === 1'b1 || cycles > int'(T) + 20) break;
        end
        exp_cycles = (ack_delay >= 0) ? ack_delay + 1 : int'(T);
        bus.ReqValid = 1'b0;
        bus.MemAck   = 1'($urandom_range(0, 1));
        check({tag, " latency"}, cycles, exp_cycles);
        check({tag, " resp"}, bus.RespValid, 1);
        check({tag, " timeout"}, bus.Timeout, (ack_delay < 0) ? 1 : 0);
        check({tag, " misaligned"}, bus.Misaligned, 0);
        check({tag, " strobes_drop"}, {bus.MemRead, bus.MemWrite}, 0);
        check({tag, " stall_resp"}, bus.Stall, 0);
        if (!wr) check({tag, " ldata"}, bus.LoadData,
                       (ack_delay < 0) ? 32'd0 : m_load(size, sgn, addr, mem[widx]));
        if (wr && ack_delay >= 0)
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[widx][8*k +: 8] = wd[8*k +: 8];
        @(posedge Clk);
        #1;
        bus.MemAck = 1'b0;
        check({tag, " resp_pulse"}, bus.RespValid, 0);
        check({tag, " back_idle"}, bus.ReqReady, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        Rst_n           = 1'b0;
        bus.ReqValid    = 1'b0;
        bus.ReqWrite    = 1'b0;
        bus.ReqSize     = 2'd0;
        bus.ReqSigned   = 1'b0;
        bus.AlUResult   = '0;
        bus.ReadData2   = '0;
        bus.MemReadData = '0;
        bus.MemAck      = 1'b0;
        #1;
        check("rst ready", bus.ReqReady, 1);
        check("rst flags", {bus.RespValid, bus.Misaligned, bus.Timeout, bus.Stall}, 0);
        check("rst strobes", {bus.MemRead, bus.MemWrite}, 0);
        check("rst ldata", bus.LoadData, 0);
        check("rst addr", bus.MemAddress, 0);
        check("rst be", bus.MemByteEn, 0);
        check("rst wdata", bus.MemWriteData, 0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;

        // aligned word store then load, ack in the first ACCESS cycle
        do_txn("sw", 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0);
        do_txn("lw", 0, 2'd2, 0, 32'h10, 32'h0, 0);
        check("lw mem", mem[4], 32'hDEAD_BEEF);

        // signed / unsigned sub-word loads
        mem[0] = 32'h80FF_7F01;
        do_txn("lb3", 0, 2'd0, 1, 32'h3, 32'h0, 0);
        do_txn("lbu3", 0, 2'd0, 0, 32'h3, 32'h0, 1);
        do_txn("lb1", 0, 2'd0, 1, 32'h1, 32'h0, 0);
        do_txn("lh2", 0, 2'd2 - 2'd1, 1, 32'h2, 32'h0, 2);
        do_txn("lhu2", 0, 2'd1, 0, 32'h2, 32'h0, 0);
        check("lb3 model", m_load(2'd0, 1, 32'h3, 32'h80FF_7F01), 32'hFFFF_FF80);
        check("lh2 model", m_load(2'd1, 1, 32'h2, 32'h80FF_7F01), 32'hFFFF_80FF);

        // byte and halfword store lanes
        do_txn("sb6", 1, 2'd0, 0, 32'h6, 32'h0000_00AB, 0);
        do_txn("sh6", 1, 2'd1, 0, 32'h6, 32'h1234_5678, 1);

        // misaligned requests never strobe memory
        do_txn("lw_mis", 0, 2'd2, 0, 32'h0E, 32'h0, 0);
        do_txn("sz3_mis", 0, 2'd3, 0, 32'h10, 32'h0, 0);
        do_txn("sh_mis", 1, 2'd1, 0, 32'h21, 32'h55AA, 0);

        // wait states and timeout
        do_txn("lw_wait3", 0, 2'd2, 0, 32'h40, 32'h0, 3);
        do_txn("lw_timeout", 0, 2'd2, 0, 32'h44, 32'h0, -1);
        do_txn("sw_timeout", 1, 2'd2, 0, 32'h48, 32'h1111_2222, -1);

        // reset while a store is pending
        mem[8] = 32'hCAFE_F00D;
        @(negedge Clk);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b1;
        bus.ReqSize   = 2'd2;
        bus.AlUResult = 32'h20;
        bus.ReadData2 = 32'h1234_5678;
        bus.MemAck    = 1'b0;
        @(posedge Clk);
        #1;
        bus.ReqValid = 1'b0;
        check("rstmid write_up", bus.MemWrite, 1);
        repeat (2) @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        check("rstmid write_drop", bus.MemWrite, 0);
        check("rstmid ready", bus.ReqReady, 1);
        check("rstmid stall", bus.Stall, 0);
        check("rstmid addr", bus.MemAddress, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        do_txn("lw_after_rst", 0, 2'd2, 0, 32'h20, 32'h0, 1);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  size = 2'($urandom_range(0, 3));
            logic [31:0] addr = $urandom;
            int          dly  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            if ($urandom_range(0, 3) != 0 && size != 2'd3)
                addr = addr & ~((32'h1 << size) - 32'h1);
            do_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), size,
                   1'($urandom_range(0, 1)), addr, $urandom, dly);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
